// File: rtl/dm_pkg.sv
// Shared op codes, FSM state type and byte-enable helper for the M-stage data memory.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package dm_pkg;

  localparam logic [2:0] DM_OP_LW  = 3'd0;
  localparam logic [2:0] DM_OP_LH  = 3'd1;
  localparam logic [2:0] DM_OP_LHU = 3'd2;
  localparam logic [2:0] DM_OP_LB  = 3'd3;
  localparam logic [2:0] DM_OP_LBU = 3'd4;
  localparam logic [2:0] DM_OP_SW  = 3'd5;
  localparam logic [2:0] DM_OP_SH  = 3'd6;
  localparam logic [2:0] DM_OP_SB  = 3'd7;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_IDLE  = 1'b1
  } dm_state_t;

  // Lanes touched by a store of the given size at the given byte offset.
  // Load codes yield no lanes, so a mis-coded store can never write.
  function automatic logic [3:0] dm_byte_en(input logic [2:0] op, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (op)
      DM_OP_SW: be = 4'b1111;
      DM_OP_SH: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      DM_OP_SB: be = 4'b0001 << addr_lo;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  output logic [31:0] rd
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Lane select followed by extension according to the load size code.
  always_comb begin
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    case (op)
      DM_OP_LH:  rd = {{16{half_sel[15]}}, half_sel};
      DM_OP_LHU: rd = {16'h0000, half_sel};
      DM_OP_LB:  rd = {{24{byte_sel[7]}}, byte_sel};
      DM_OP_LBU: rd = {24'h000000, byte_sel};
      default:   rd = word;
    endcase
  end

endmodule

// File: rtl/dm_byte_lane.sv
// M-stage data memory: byte-lane stores, extending loads, address exceptions, post-reset clear.
// Latency: stores commit at the accepting edge; load data and exception flags appear one cycle later.
// Backpressure: busy is high while the array is being zeroed and requests are dropped; none otherwise.
module dm_byte_lane
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int IDX_W       = 12,
  parameter bit LOG_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wpc,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        rd_valid,
  output logic        busy,
  output logic        exc_adel,
  output logic        exc_ades
);

  dm_state_t        state;
  dm_state_t        state_next;
  logic [IDX_W-1:0] clr_idx;
  logic             clr_last;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             acc;
  logic             is_word;
  logic             is_half;
  logic             op_undef;
  logic             misal;
  logic             oor;
  logic             bad;
  logic             do_st;
  logic             do_ld;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wd_rep;
  logic [31:0]      cur;
  logic [31:0]      merged;

  logic [31:0]      hold_word;
  logic [2:0]       hold_op;
  logic [1:0]       hold_lo;

  assign clr_last = (clr_idx == IDX_W'(DEPTH_WORDS - 1));
  assign acc      = req && (state == DM_IDLE);
  assign idx      = addr[IDX_W+1:2];
  assign cur      = mem[idx];

  // Request decode: size class, op/direction mismatch, alignment and range checks.
  always_comb begin
    is_word  = (op == DM_OP_LW) || (op == DM_OP_SW);
    is_half  = (op == DM_OP_LH) || (op == DM_OP_LHU) || (op == DM_OP_SH);
    op_undef = we ? (op < DM_OP_SW) : (op >= DM_OP_SW);
    misal    = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
    oor      = (addr[31:2] >= 30'(DEPTH_WORDS));
    bad      = op_undef || misal || oor;
    do_st    = acc && we && !bad;
    do_ld    = acc && !we && !bad;
  end

  // Store data: replicate the right-aligned value across lanes, then merge enabled lanes.
  always_comb begin
    be = dm_byte_en(op, addr[1:0]);
    case (op)
      DM_OP_SB: wd_rep = {4{wd[7:0]}};
      DM_OP_SH: wd_rep = {2{wd[15:0]}};
      default:  wd_rep = wd;
    endcase
    merged = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wd_rep[8*i +: 8];
    end
  end

  // Next state: leave CLEAR once the last word is being zeroed.
  always_comb begin
    state_next = state;
    case (state)
      DM_CLEAR: if (clr_last) state_next = DM_IDLE;
      DM_IDLE:  state_next = DM_IDLE;
      default:  state_next = DM_CLEAR;
    endcase
  end

  // Control state, clear counter, load holding register and response flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DM_CLEAR;
      clr_idx   <= '0;
      busy      <= 1'b1;
      rd_valid  <= 1'b0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
      hold_word <= '0;
      hold_op   <= DM_OP_LW;
      hold_lo   <= 2'b00;
    end else begin
      state    <= state_next;
      busy     <= (state_next == DM_CLEAR);
      rd_valid <= do_ld;
      exc_adel <= acc && !we && bad;
      exc_ades <= acc && we && bad;
      if (state == DM_CLEAR) clr_idx <= clr_idx + 1'b1;
      if (do_ld) begin
        hold_word <= cur;
        hold_op   <= op;
        hold_lo   <= addr[1:0];
      end
    end
  end

  // Array write port: zeroing sweep while clearing, merged store word otherwise.
  always_ff @(posedge clk) begin
    if (state == DM_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (do_st) begin
      mem[idx] <= merged;
    end
  end

  // Store trace for simulation runs.
  always_ff @(posedge clk) begin
    if (LOG_EN && do_st) begin
      $display("%d@%h: *%h <= %h", $time, wpc, {addr[31:2], 2'b00}, merged);
    end
  end

  dm_load_ext u_ext (
    .word    (hold_word),
    .op      (hold_op),
    .addr_lo (hold_lo),
    .rd      (rd)
  );

endmodule

// File: tb/tb_dm_byte_lane.sv
// Directed bench for dm_byte_lane: clear timing, byte-lane stores, extended loads, exceptions.
// Latency: inputs change 1 time unit after a rising edge and outputs are sampled 1 unit after the next.
// Backpressure: requests issued while busy are expected to be ignored.
module tb_dm_byte_lane;
  import dm_pkg::*;

  localparam int DEPTH = 3072;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wpc;
  logic        req;
  logic        we;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        rd_valid;
  logic        busy;
  logic        exc_adel;
  logic        exc_ades;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  always #5 clk = ~clk;

  dm_byte_lane #(.DEPTH_WORDS(DEPTH), .IDX_W(12), .LOG_EN(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .wpc      (wpc),
    .req      (req),
    .we       (we),
    .op       (op),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .rd_valid (rd_valid),
    .busy     (busy),
    .exc_adel (exc_adel),
    .exc_ades (exc_ades)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    req  = 1'b1;
    we   = w;
    op   = o;
    addr = a;
    wd   = d;
    wpc  = wpc + 32'd4;
    tick();
    req  = 1'b0;
    we   = 1'b0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    wpc   = 32'h0040_0000;
    req   = 1'b0;
    we    = 1'b0;
    op    = DM_OP_LW;
    addr  = '0;
    wd    = '0;

    // Reset state
    tick();
    chk("rst_busy",     32'(busy),     32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd",       rd,            32'h0);
    chk("rst_exc",      {30'd0, exc_adel, exc_ades}, 32'd0);
    tick();
    reset = 1'b1;

    // Clear duration
    wait_clear(cyc);
    chk("clear_cycles", 32'(cyc),  32'(DEPTH));
    chk("clear_busy",   32'(busy), 32'd0);

    // Cleared contents at both ends of the array
    access(1'b0, DM_OP_LW, 32'h0, 32'h0);
    chk("lw0_valid", 32'(rd_valid), 32'd1);
    chk("lw0_rd",    rd,            32'h0);
    access(1'b0, DM_OP_LW, 32'h2FFC, 32'h0);
    chk("lwtop_valid", 32'(rd_valid), 32'd1);
    chk("lwtop_rd",    rd,            32'h0);

    // Word then byte store into the same word
    access(1'b1, DM_OP_SW, 32'h10, 32'h1122_3344);
    chk("sw_no_valid", 32'(rd_valid), 32'd0);
    access(1'b1, DM_OP_SB, 32'h11, 32'h0000_00AB);
    access(1'b0, DM_OP_LW, 32'h10, 32'h0);
    chk("merge_valid", 32'(rd_valid), 32'd1);
    chk("merge_rd",    rd,            32'h1122_AB44);

    // Upper half store and extending loads
    access(1'b1, DM_OP_SH, 32'h22, 32'h0000_8001);
    access(1'b0, DM_OP_LH, 32'h22, 32'h0);
    chk("lh_rd", rd, 32'hFFFF_8001);
    access(1'b0, DM_OP_LHU, 32'h22, 32'h0);
    chk("lhu_rd", rd, 32'h0000_8001);
    access(1'b0, DM_OP_LB, 32'h23, 32'h0);
    chk("lb_rd", rd, 32'hFFFF_FF80);
    access(1'b0, DM_OP_LBU, 32'h23, 32'h0);
    chk("lbu_rd", rd, 32'h0000_0080);
    access(1'b0, DM_OP_LW, 32'h20, 32'h0);
    chk("sh_word", rd, 32'h8001_0000);

    // Misaligned store: flag pulses, memory untouched
    access(1'b1, DM_OP_SW, 32'h13, 32'hCAFE_F00D);
    chk("ades_mis", 32'(exc_ades), 32'd1);
    chk("ades_adel", 32'(exc_adel), 32'd0);
    tick();
    chk("ades_pulse", 32'(exc_ades), 32'd0);
    access(1'b0, DM_OP_LW, 32'h10, 32'h0);
    chk("ades_nowrite", rd, 32'h1122_AB44);

    // Misaligned half load
    access(1'b0, DM_OP_LH, 32'h31, 32'h0);
    chk("adel_mis",   32'(exc_adel), 32'd1);
    chk("adel_novld", 32'(rd_valid), 32'd0);
    chk("adel_rdhold", rd, 32'h1122_AB44);

    // Out-of-range load
    access(1'b0, DM_OP_LW, 32'h3000, 32'h0);
    chk("adel_oor",   32'(exc_adel), 32'd1);
    chk("oor_novld",  32'(rd_valid), 32'd0);

    // Store followed immediately by a load of the same word
    access(1'b1, DM_OP_SW, 32'h40, 32'hDEAD_BEEF);
    access(1'b0, DM_OP_LW, 32'h40, 32'h0);
    chk("b2b_valid", 32'(rd_valid), 32'd1);
    chk("b2b_rd",    rd,            32'hDEAD_BEEF);
    tick();
    chk("idle_novld", 32'(rd_valid), 32'd0);
    chk("idle_rdhold", rd, 32'hDEAD_BEEF);

    // Direction/size mismatches
    access(1'b0, DM_OP_SW, 32'h40, 32'h0);
    chk("undef_ld_exc", 32'(exc_adel), 32'd1);
    chk("undef_ld_vld", 32'(rd_valid), 32'd0);
    access(1'b1, DM_OP_LW, 32'h44, 32'h1234_5678);
    chk("undef_st_exc", 32'(exc_ades), 32'd1);
    access(1'b0, DM_OP_LW, 32'h44, 32'h0);
    chk("undef_st_nowrite", rd, 32'h0);

    // Reset mid-clear restarts the sweep; requests during busy are ignored
    access(1'b0, DM_OP_LW, 32'h40, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst2_async_rd",   rd,         32'h0);
    chk("rst2_async_busy", 32'(busy),  32'd1);
    tick();
    tick();
    reset = 1'b1;
    repeat (100) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    repeat (200) tick();
    access(1'b1, DM_OP_SW, 32'h50, 32'hFFFF_FFFF);
    chk("busy_st_exc", 32'(exc_ades), 32'd0);
    access(1'b1, DM_OP_SW, 32'h53, 32'hFFFF_FFFF);
    chk("busy_mis_exc", 32'(exc_ades), 32'd0);
    access(1'b0, DM_OP_LW, 32'h50, 32'h0);
    chk("busy_ld_vld", 32'(rd_valid), 32'd0);
    chk("busy_ld_exc", 32'(exc_adel), 32'd0);
    wait_clear(cyc);
    chk("reclear_cycles", 32'(cyc + 203), 32'(DEPTH));
    access(1'b0, DM_OP_LW, 32'h50, 32'h0);
    chk("busy_nowrite", rd, 32'h0);
    access(1'b0, DM_OP_LW, 32'h10, 32'h0);
    chk("recleared_rd",  rd,            32'h0);
    chk("recleared_vld", 32'(rd_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
